// File: rtl/dmi_host_sequencer.sv
// Host-command to DMI request/response sequencer with sticky error status,
// response timeout and DMI-side reset generation.
module dmi_host_sequencer #(
    parameter int unsigned TimeoutCycles = 256,
    parameter int unsigned AddrWidth     = 7
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic                   cmd_write_i,
    input  logic [AddrWidth-1:0]   cmd_addr_i,
    input  logic [31:0]            cmd_wdata_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [31:0]            rsp_rdata_o,
    output logic [1:0]             rsp_err_o,
    input  logic                   dmireset_i,
    input  logic                   dmihardreset_i,
    output logic [1:0]             status_o,
    output logic                   dmi_rst_no,
    output logic                   dmi_req_valid_o,
    input  logic                   dmi_req_ready_i,
    output logic [AddrWidth+33:0]  dmi_req_o,
    input  logic                   dmi_resp_valid_i,
    output logic                   dmi_resp_ready_o,
    input  logic [33:0]            dmi_resp_i
);

    localparam int unsigned DataW       = 32;
    localparam int unsigned OpW         = 2;
    localparam int unsigned ErrW        = 2;
    localparam int unsigned TimerW      = $clog2(TimeoutCycles + 2);
    localparam int unsigned TimeoutLast = (TimeoutCycles == 0) ? 0 : TimeoutCycles - 1;

    localparam logic [OpW-1:0]  OpRead    = OpW'(1);
    localparam logic [OpW-1:0]  OpWrite   = OpW'(2);
    localparam logic [ErrW-1:0] ErrOk     = ErrW'(0);
    localparam logic [ErrW-1:0] ErrFailed = ErrW'(2);
    localparam logic [ErrW-1:0] ErrBusy   = ErrW'(3);

    if (AddrWidth != 7) begin : g_bad_addr_width
        $error("dmi_host_sequencer: AddrWidth must be 7");
    end

    typedef struct packed {
        logic [AddrWidth-1:0] addr;
        logic [OpW-1:0]       op;
        logic [DataW-1:0]     data;
    } dmi_req_t;

    typedef struct packed {
        logic [DataW-1:0] data;
        logic [ErrW-1:0]  resp;
    } dmi_resp_t;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StRsp,
        StDrain
    } state_e;

    state_e            state_q, state_d;
    logic [ErrW-1:0]   status_q, status_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic              drain_q, drain_d;
    dmi_req_t          req_q, req_d;
    logic [DataW-1:0]  rdata_q, rdata_d;
    logic [ErrW-1:0]   err_q, err_d;
    logic              rsp_valid_q;
    logic              req_valid_q;
    logic              dmi_rst_n_q;
    logic              status_set;
    logic [ErrW-1:0]   status_new;
    dmi_resp_t         resp;

    assign resp = dmi_resp_i;

    // Next-state and datapath updates; hard reset overrides the FSM, error set overrides dmireset.
    always_comb begin
        state_d    = state_q;
        status_d   = status_q;
        timer_d    = timer_q;
        drain_d    = drain_q;
        req_d      = req_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        status_set = 1'b0;
        status_new = status_q;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid_i) begin
                    if (status_q == ErrOk) begin
                        req_d   = '{addr: cmd_addr_i,
                                    op:   (cmd_write_i ? OpWrite : OpRead),
                                    data: cmd_wdata_i};
                        state_d = StReq;
                    end else begin
                        // Sticky error short-circuits the command without touching DMI.
                        err_d   = status_q;
                        rdata_d = '0;
                        state_d = StRsp;
                    end
                end
            end
            StReq: begin
                if (dmi_req_ready_i) begin
                    timer_d = '0;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (dmi_resp_valid_i) begin
                    rdata_d = resp.data;
                    err_d   = resp.resp;
                    state_d = StRsp;
                    if (resp.resp != ErrOk) begin
                        status_set = 1'b1;
                        status_new = (resp.resp == ErrBusy) ? ErrBusy : ErrFailed;
                    end
                end else if ((TimeoutCycles != 0) && (timer_q == TimerW'(TimeoutLast))) begin
                    // The late response still has to be absorbed, hence the drain.
                    rdata_d    = '0;
                    err_d      = ErrBusy;
                    status_set = 1'b1;
                    status_new = ErrBusy;
                    drain_d    = 1'b1;
                    state_d    = StRsp;
                end else if (timer_q != '1) begin
                    timer_d = timer_q + TimerW'(1);
                end
            end
            StRsp: begin
                if (rsp_ready_i) begin
                    state_d = drain_q ? StDrain : StIdle;
                end
            end
            StDrain: begin
                if (dmi_resp_valid_i) begin
                    drain_d = 1'b0;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (status_set) begin
            status_d = status_new;
        end else if (dmireset_i) begin
            status_d = ErrOk;
        end

        if (dmihardreset_i) begin
            state_d  = StIdle;
            drain_d  = 1'b0;
            status_d = ErrOk;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            status_q    <= ErrOk;
            timer_q     <= '0;
            drain_q     <= 1'b0;
            req_q       <= '0;
            rdata_q     <= '0;
            err_q       <= ErrOk;
            rsp_valid_q <= 1'b0;
            req_valid_q <= 1'b0;
            dmi_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            status_q    <= status_d;
            timer_q     <= timer_d;
            drain_q     <= drain_d;
            req_q       <= req_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            rsp_valid_q <= (state_d == StRsp);
            req_valid_q <= (state_d == StReq);
            dmi_rst_n_q <= ~dmihardreset_i;
        end
    end

    assign cmd_ready_o      = (state_q == StIdle);
    assign dmi_resp_ready_o = (state_q == StWait) || (state_q == StDrain);
    assign rsp_valid_o      = rsp_valid_q;
    assign rsp_rdata_o      = rdata_q;
    assign rsp_err_o        = err_q;
    assign status_o         = status_q;
    assign dmi_rst_no       = dmi_rst_n_q;
    assign dmi_req_valid_o  = req_valid_q;
    assign dmi_req_o        = req_q;

endmodule
